// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped debug UART transmitter (byte FIFO + 8N1 serializer)
// Stores to TX_ADDR queue bytes; loads from STATUS_ADDR report FIFO/serializer state.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] TX_ADDR      = 32'h0000_1000,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_1004
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        uart_tx,
  output logic [7:0]  tx_Data,
  output logic        tx_DataValid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;

  logic          w_full;
  logic          w_empty;
  logic          w_tx_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_done;
  logic          w_uart_tx;
  logic [7:0]    w_count8;
  logic          w_unused;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_tx_hit    = MemWriteM && (AddrM == TX_ADDR);
  assign w_push      = w_tx_hit && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_baud_done = (r_baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign w_unused    = &{1'b0, WriteDataM[31:8]};

  // Stall uses the registered full flag, so a same-cycle pop never releases it early.
  assign StallM = w_tx_hit && w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= WriteDataM[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty)                          w_state_next = S_START;
      S_START: if (w_baud_done)                       w_state_next = S_DATA;
      S_DATA:  if (w_baud_done && r_bit_idx == 3'd7)  w_state_next = S_STOP;
      S_STOP:  if (w_baud_done)                       w_state_next = S_IDLE;
      default:                                        w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_uart_tx = 1'b1;
    case (r_state)
      S_START: w_uart_tx = 1'b0;
      S_DATA:  w_uart_tx = r_shift[0];
      default: w_uart_tx = 1'b1;
    endcase
  end

  assign uart_tx = w_uart_tx;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_baud_done) r_baud_cnt <= '0;
      else                                  r_baud_cnt <= r_baud_cnt + BW'(1);

      if (r_state != S_DATA)  r_bit_idx <= '0;
      else if (w_baud_done)   r_bit_idx <= r_bit_idx + 3'd1;

      if (w_pop)                                 r_shift <= r_mem[r_rd_ptr];
      else if (r_state == S_DATA && w_baud_done) r_shift <= {1'b0, r_shift[7:1]};

      r_tx_valid <= w_pop;
      if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
    end
  end

  assign tx_Data      = r_tx_data;
  assign tx_DataValid = r_tx_valid;

  always_comb begin
    w_count8 = '0;
    for (int i = 0; i < CW && i < 8; i++) w_count8[i] = r_count[i];
  end

  always_comb begin
    ReadDataM = '0;
    if (MemReadM && AddrM == STATUS_ADDR)
      ReadDataM = {16'b0, w_count8, 5'b0, (r_state != S_IDLE), w_empty, w_full};
  end

endmodule
